// File: rtl/csi2_pkg.sv
// csi2_pkg: shared constants and types for the CSI-2 receiver.
//   SYNC_BYTE   - HS leader byte hunted for on every lane.
//   DT_LONG_MIN - first data type that denotes a long packet.
//   state_t     - packet parser states.
package csi2_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hB8;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [1:0] {
    HUNT,
    HEADER,
    PAYLOAD,
    CRC
  } state_t;

endpackage

// File: rtl/csi2_lane_rx.sv
// csi2_lane_rx: one D-PHY HS data lane.
//   clock_p       in  lane clock, bits taken on both edges
//   reset         in  async active-high
//   data          in  serial HS bit, LSB first
//   restart       in  pulse: realign byte counter to the sync just matched
//   restart_phase in  1 = sync ended on the negedge bit, 0 = on the posedge bit
//   match_mid     out shift window after the negedge bit equals SYNC_BYTE
//   match_new     out shift window after the posedge bit equals SYNC_BYTE
//   lane_byte     out completed lane byte
//   byte_valid    out one-cycle strobe for lane_byte
module csi2_lane_rx
  import csi2_pkg::*;
(
  input  logic       clock_p,
  input  logic       reset,
  input  logic       data,
  input  logic       restart,
  input  logic       restart_phase,
  output logic       match_mid,
  output logic       match_new,
  output logic [7:0] lane_byte,
  output logic       byte_valid
);

  logic       neg_bit;
  logic [7:0] sreg;
  logic [7:0] mid;
  logic [7:0] nxt;
  logic [1:0] cnt;
  logic       phase;

  always_ff @(negedge clock_p or posedge reset) begin
    if (reset) neg_bit <= 1'b0;
    else       neg_bit <= data;
  end

  // Two bits enter per posedge: the negedge bit first, then the posedge bit.
  // Both intermediate windows are exposed so sync can land on either edge.
  always_comb begin
    mid       = {neg_bit, sreg[7:1]};
    nxt       = {data, mid[7:1]};
    match_mid = (mid == SYNC_BYTE);
    match_new = (nxt == SYNC_BYTE);
  end

  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
      lane_byte  <= '0;
      byte_valid <= 1'b0;
    end else begin
      sreg <= nxt;
      if (restart) begin
        cnt        <= '0;
        phase      <= restart_phase;
        byte_valid <= 1'b0;
      end else begin
        cnt        <= cnt + 2'd1;
        byte_valid <= (cnt == 2'd3);
        if (cnt == 2'd3) lane_byte <= phase ? mid : nxt;
      end
    end
  end

endmodule

// File: rtl/csi2_camera.sv
// csi2_camera: MIPI CSI-2 packet receiver behind a 1/2/4-lane D-PHY.
//   clock_p           in  HS clock, data sampled on both edges
//   reset             in  async active-high, returns to sync hunt
//   data_p            in  one HS bit per lane per edge
//   virtual_channel   out DI[7:6] of last header
//   word_count        out WC of last header
//   image_data_type   out DI[5:0] of last header
//   image_data        out payload word, [0] earliest byte
//   image_data_enable out image_data valid strobe
//   interrupt         out word / short-packet / end-of-packet strobe
module csi2_camera
  import csi2_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2
) (
  input  logic                 clock_p,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] data_p,
  output logic [1:0]           virtual_channel,
  output logic [15:0]          word_count,
  output logic [5:0]           image_data_type,
  output logic [7:0]           image_data [3:0],
  output logic                 image_data_enable,
  output logic                 interrupt
);

  logic [NUM_LANES-1:0] match_mid;
  logic [NUM_LANES-1:0] match_new;
  logic [NUM_LANES-1:0] byte_valid;
  logic [7:0]           lane_byte [NUM_LANES];
  logic                 restart;
  logic                 restart_phase;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    csi2_lane_rx u_lane (
      .clock_p       (clock_p),
      .reset         (reset),
      .data          (data_p[g]),
      .restart       (restart),
      .restart_phase (restart_phase),
      .match_mid     (match_mid[g]),
      .match_new     (match_new[g]),
      .lane_byte     (lane_byte[g]),
      .byte_valid    (byte_valid[g])
    );
  end

  state_t          state, n_state;
  logic [15:0]     cnt, n_cnt;
  logic [7:0]      di, n_di, wcl, n_wcl, wch, n_wch;
  logic [1:0]      wpos, n_wpos;
  logic [3:0][7:0] word_buf, n_word;
  logic            eop_pending;
  logic            emit_word, emit_eop, hdr_done;
  logic [7:0]      b;

  assign restart       = (state == HUNT) && ((&match_mid) || (&match_new));
  assign restart_phase = &match_mid;

  // All lane bytes of a byte-time arrive together; walk them lane 0 first,
  // letting the parser state advance between bytes within the same cycle.
  always_comb begin
    n_state   = state;
    n_cnt     = cnt;
    n_di      = di;
    n_wcl     = wcl;
    n_wch     = wch;
    n_wpos    = wpos;
    n_word    = word_buf;
    emit_word = 1'b0;
    emit_eop  = 1'b0;
    hdr_done  = 1'b0;
    b         = '0;
    if (restart) begin
      n_state = HEADER;
      n_cnt   = '0;
    end else if ((&byte_valid) && (state != HUNT)) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        b = lane_byte[i];
        case (n_state)
          HEADER: begin
            case (n_cnt[1:0])
              2'd0: n_di  = b;
              2'd1: n_wcl = b;
              2'd2: n_wch = b;
              default: begin
                hdr_done = 1'b1;
                n_cnt    = '0;
                if (n_di[5:0] < DT_LONG_MIN) begin
                  emit_eop = 1'b1;
                  n_state  = HUNT;
                end else if ({n_wch, n_wcl} == 16'd0) begin
                  n_state = CRC;
                end else begin
                  n_state = PAYLOAD;
                  n_wpos  = '0;
                end
              end
            endcase
            if (n_state == HEADER) n_cnt = n_cnt + 16'd1;
          end
          PAYLOAD: begin
            if (n_wpos == 2'd0) n_word = '0;
            n_word[n_wpos] = b;
            if (n_wpos == 2'd3 || n_cnt == {n_wch, n_wcl} - 16'd1) emit_word = 1'b1;
            if (n_cnt == {n_wch, n_wcl} - 16'd1) begin
              n_state = CRC;
              n_cnt   = '0;
            end else begin
              n_cnt = n_cnt + 16'd1;
            end
            n_wpos = n_wpos + 2'd1;
          end
          CRC: begin
            if (n_cnt[0]) begin
              emit_eop = 1'b1;
              n_state  = HUNT;
            end else begin
              n_cnt = n_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A final word and end-of-packet in one byte-time (4 lanes) are split:
  // the word strobes first, the end-of-packet pulse follows a cycle later.
  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      state             <= HUNT;
      cnt               <= '0;
      di                <= '0;
      wcl               <= '0;
      wch               <= '0;
      wpos              <= '0;
      word_buf          <= '0;
      eop_pending       <= 1'b0;
      virtual_channel   <= '0;
      word_count        <= '0;
      image_data_type   <= '0;
      image_data_enable <= 1'b0;
      interrupt         <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) image_data[k] <= '0;
    end else begin
      state             <= n_state;
      cnt               <= n_cnt;
      di                <= n_di;
      wcl               <= n_wcl;
      wch               <= n_wch;
      wpos              <= n_wpos;
      word_buf          <= n_word;
      eop_pending       <= emit_word & emit_eop;
      image_data_enable <= emit_word;
      interrupt         <= emit_word | emit_eop | eop_pending;
      if (hdr_done) begin
        virtual_channel <= n_di[7:6];
        image_data_type <= n_di[5:0];
        word_count      <= {n_wch, n_wcl};
      end
      if (emit_word) begin
        for (int unsigned k = 0; k < 4; k++) image_data[k] <= n_word[k];
      end
    end
  end

endmodule

// File: tb/tb_csi2_camera.sv
// tb_csi2_camera: directed self-checking bench for csi2_camera (2 lanes).
module tb_csi2_camera;

  localparam int NL = 2;

  logic          clock_p = 1'b0;
  logic          reset;
  logic [NL-1:0] data_p;
  logic [1:0]    virtual_channel;
  logic [15:0]   word_count;
  logic [5:0]    image_data_type;
  logic [7:0]    image_data [3:0];
  logic          image_data_enable;
  logic          interrupt;

  csi2_camera #(.NUM_LANES(NL)) dut (
    .clock_p           (clock_p),
    .reset             (reset),
    .data_p            (data_p),
    .virtual_channel   (virtual_channel),
    .word_count        (word_count),
    .image_data_type   (image_data_type),
    .image_data        (image_data),
    .image_data_enable (image_data_enable),
    .interrupt         (interrupt)
  );

  always #5 clock_p = ~clock_p;

  typedef struct packed {
    logic        en;
    logic [31:0] word;
  } ev_t;

  ev_t evq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(negedge clock_p) begin
    if (interrupt || image_data_enable)
      evq.push_back({image_data_enable,
                     image_data[3], image_data[2], image_data[1], image_data[0]});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [NL-1:0] v);
    @(clock_p);
    #1 data_p = v;
  endtask

  task automatic send(input logic [7:0] pkt[$], input int flush);
    logic [NL-1:0] v;
    logic [7:0]    t;
    for (int k = 0; k < pkt.size(); k += NL) begin
      for (int bi = 0; bi < 8; bi++) begin
        v = '0;
        for (int l = 0; l < NL; l++) begin
          if (k + l < pkt.size()) begin
            t    = pkt[k + l];
            v[l] = t[bi];
          end
        end
        put(v);
      end
    end
    repeat (flush) put('0);
  endtask

  task automatic check_ev(input string tag, input int idx, input logic en,
                          input logic [31:0] w);
    if (idx < evq.size()) begin
      check({tag, "_en"}, 32'(evq[idx].en), 32'(en));
      if (en) check({tag, "_word"}, evq[idx].word, w);
    end
  endtask

  task automatic check_hdr(input string tag, input logic [1:0] vc,
                           input logic [5:0] dt, input logic [15:0] wc);
    check({tag, "_vc"}, 32'(virtual_channel), 32'(vc));
    check({tag, "_dt"}, 32'(image_data_type), 32'(dt));
    check({tag, "_wc"}, 32'(word_count), 32'(wc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pkt[$];
    reset  = 1'b1;
    data_p = '0;
    repeat (3) @(posedge clock_p);
    #1;
    check("rst_int", 32'(interrupt), 32'd0);
    check("rst_en", 32'(image_data_enable), 32'd0);
    check("rst_word", {image_data[3], image_data[2], image_data[1], image_data[0]}, 32'd0);
    check_hdr("rst", 2'd0, 6'h00, 16'h0000);
    reset = 1'b0;
    repeat (4) put('0);

    // Short packet
    evq.delete();
    pkt = '{8'hB8, 8'hB8, 8'h08, 8'hCE, 8'hFA, 8'h12};
    send(pkt, 24);
    check("short_nev", 32'(evq.size()), 32'd1);
    check_ev("short_ev0", 0, 1'b0, 32'd0);
    check_hdr("short", 2'd0, 6'h08, 16'hFACE);

    // Long packet, WC=8
    evq.delete();
    pkt = '{8'hB8, 8'hB8, 8'h18, 8'h08, 8'h00, 8'hFE, 8'hAD, 8'hDE,
            8'hE1, 8'hFE, 8'h5E, 8'hEA, 8'h15, 8'h0D, 8'hD0, 8'hF0};
    send(pkt, 24);
    check("long_nev", 32'(evq.size()), 32'd3);
    check_ev("long_ev0", 0, 1'b1, 32'hFEE1DEAD);
    check_ev("long_ev1", 1, 1'b1, 32'h0D15EA5E);
    check_ev("long_ev2", 2, 1'b0, 32'd0);
    check_hdr("long", 2'd0, 6'h18, 16'd8);

    // Long idle of zeros, then the same packet shifted by one edge
    evq.delete();
    repeat (200) put('0);
    check("idle_nev", 32'(evq.size()), 32'd0);
    put('0);
    send(pkt, 24);
    check("odd_nev", 32'(evq.size()), 32'd3);
    check_ev("odd_ev0", 0, 1'b1, 32'hFEE1DEAD);
    check_ev("odd_ev1", 1, 1'b1, 32'h0D15EA5E);
    check_ev("odd_ev2", 2, 1'b0, 32'd0);

    // Long packet, WC=6: partial final word
    evq.delete();
    pkt = '{8'hB8, 8'hB8, 8'h2A, 8'h06, 8'h00, 8'h5C, 8'h01, 8'h02,
            8'h03, 8'h04, 8'h05, 8'h06, 8'hC1, 8'hC2};
    send(pkt, 24);
    check("wc6_nev", 32'(evq.size()), 32'd3);
    check_ev("wc6_ev0", 0, 1'b1, 32'h04030201);
    check_ev("wc6_ev1", 1, 1'b1, 32'h00000605);
    check_ev("wc6_ev2", 2, 1'b0, 32'd0);
    check_hdr("wc6", 2'd0, 6'h2A, 16'd6);

    // Long packet, WC=0: straight to CRC
    evq.delete();
    pkt = '{8'hB8, 8'hB8, 8'h12, 8'h00, 8'h00, 8'h33, 8'hC1, 8'hC2};
    send(pkt, 24);
    check("wc0_nev", 32'(evq.size()), 32'd1);
    check_ev("wc0_ev0", 0, 1'b0, 32'd0);
    check_hdr("wc0", 2'd0, 6'h12, 16'd0);

    // Reset during payload
    evq.delete();
    pkt = '{8'hB8, 8'hB8, 8'h18, 8'h08, 8'h00, 8'hFE, 8'hAD, 8'hDE};
    send(pkt, 6);
    check("mid_wc", 32'(word_count), 32'd8);
    reset = 1'b1;
    #1;
    check("mid_rst_int", 32'(interrupt), 32'd0);
    check("mid_rst_en", 32'(image_data_enable), 32'd0);
    check_hdr("mid_rst", 2'd0, 6'h00, 16'h0000);
    repeat (4) @(posedge clock_p);
    #1 reset = 1'b0;
    repeat (40) put('0);
    check("mid_nev", 32'(evq.size()), 32'd0);

    // DI=0xC1 short packet after reset
    evq.delete();
    pkt = '{8'hB8, 8'hB8, 8'hC1, 8'h34, 8'h12, 8'h77};
    send(pkt, 24);
    check("c1_nev", 32'(evq.size()), 32'd1);
    check_ev("c1_ev0", 0, 1'b0, 32'd0);
    check_hdr("c1", 2'd3, 6'h01, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
